// File: rtl/byte_stripping_pkg.sv
// Shared definitions for the byte striper: default widths, idle byte and FSM encodings.
// Optional feature macro used across this slice: STRIPE_PARITY_EN.
package byte_stripping_pkg;

  localparam int unsigned DATA_W_DEF    = 8;
  localparam logic [7:0]  IDLE_BYTE_DEF = 8'h00;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_HALF  = 1'b1;

endpackage

// File: rtl/byte_stripping_if.sv
// Byte-stream input and two-lane striped output bundle for byte_stripping.
// Lane parity members exist only when STRIPE_PARITY_EN is defined.
interface byte_stripping_if #(
  parameter int unsigned DATA_W = 8
);

  logic [DATA_W-1:0] data_in;
  logic              valid_in;
  logic [DATA_W-1:0] data_stripe_0;
  logic [DATA_W-1:0] data_stripe_1;
  logic              valid_stripe_0;
  logic              valid_stripe_1;
`ifdef STRIPE_PARITY_EN
  logic              parity_stripe_0;
  logic              parity_stripe_1;
`endif

  modport master (
    output data_in,
    output valid_in,
`ifdef STRIPE_PARITY_EN
    input  parity_stripe_0,
    input  parity_stripe_1,
`endif
    input  data_stripe_0,
    input  data_stripe_1,
    input  valid_stripe_0,
    input  valid_stripe_1
  );

  modport slave (
    input  data_in,
    input  valid_in,
`ifdef STRIPE_PARITY_EN
    output parity_stripe_0,
    output parity_stripe_1,
`endif
    output data_stripe_0,
    output data_stripe_1,
    output valid_stripe_0,
    output valid_stripe_1
  );

endinterface

// File: rtl/byte_stripping_stripe_lane_reg.sv
// Load-enabled lane output register (data, valid, optional parity) with sync active-low reset.
// Parity output present only when STRIPE_PARITY_EN is defined.
module stripe_lane_reg #(
  parameter int unsigned       DATA_W    = 8,
  parameter logic [DATA_W-1:0] IDLE_BYTE = '0
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              load,
  input  logic              d_valid,
  input  logic [DATA_W-1:0] d_data,
`ifdef STRIPE_PARITY_EN
  output logic              q_parity,
`endif
  output logic              q_valid,
  output logic [DATA_W-1:0] q_data
);

  // Invalid lanes always carry the idle byte so stale data is never repeated.
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      q_valid  <= 1'b0;
      q_data   <= IDLE_BYTE;
`ifdef STRIPE_PARITY_EN
      q_parity <= 1'b0;
`endif
    end else if (load) begin
      q_valid  <= d_valid;
      q_data   <= d_valid ? d_data : IDLE_BYTE;
`ifdef STRIPE_PARITY_EN
      q_parity <= d_valid & (^d_data);
`endif
    end
  end

endmodule

// File: rtl/byte_stripping.sv
// Transmit-side byte striper: one clk_2f byte stream split over two half-rate lanes.
// STRIPE_PARITY_EN adds per-lane even parity outputs.
module byte_stripping
  import byte_stripping_pkg::*;
#(
  parameter int unsigned       DATA_W    = DATA_W_DEF,
  parameter logic [DATA_W-1:0] IDLE_BYTE = DATA_W'(IDLE_BYTE_DEF)
) (
  input  logic            clk_2f,
  input  logic            reset_L,
  byte_stripping_if.slave bus
);

  logic              ph;
  logic [0:0]        state;
  logic [DATA_W-1:0] hold;

  logic              lane0_valid;
  logic              lane1_valid;
  logic [DATA_W-1:0] lane0_data;

  // HALF is only ever entered at ph=0, so every ph=1 cycle returns to EMPTY.
  always_ff @(posedge clk_2f) begin
    if (!reset_L) begin
      ph    <= 1'b0;
      state <= ST_EMPTY;
      hold  <= IDLE_BYTE;
    end else begin
      ph <= ~ph;
      if (state == ST_EMPTY && bus.valid_in && !ph) begin
        state <= ST_HALF;
        hold  <= bus.data_in;
      end else begin
        state <= ST_EMPTY;
      end
    end
  end

  // First byte of a period always lands on lane 0.
  always_comb begin
    lane0_valid = 1'b0;
    lane1_valid = 1'b0;
    lane0_data  = bus.data_in;
    if (state == ST_HALF) begin
      lane0_valid = 1'b1;
      lane0_data  = hold;
      lane1_valid = bus.valid_in;
    end else begin
      lane0_valid = bus.valid_in;
    end
  end

  stripe_lane_reg #(
    .DATA_W    (DATA_W),
    .IDLE_BYTE (IDLE_BYTE)
  ) u_lane0 (
    .clk      (clk_2f),
    .reset_L  (reset_L),
    .load     (ph),
    .d_valid  (lane0_valid),
    .d_data   (lane0_data),
`ifdef STRIPE_PARITY_EN
    .q_parity (bus.parity_stripe_0),
`endif
    .q_valid  (bus.valid_stripe_0),
    .q_data   (bus.data_stripe_0)
  );

  stripe_lane_reg #(
    .DATA_W    (DATA_W),
    .IDLE_BYTE (IDLE_BYTE)
  ) u_lane1 (
    .clk      (clk_2f),
    .reset_L  (reset_L),
    .load     (ph),
    .d_valid  (lane1_valid),
    .d_data   (bus.data_in),
`ifdef STRIPE_PARITY_EN
    .q_parity (bus.parity_stripe_1),
`endif
    .q_valid  (bus.valid_stripe_1),
    .q_data   (bus.data_stripe_1)
  );

endmodule

// File: tb/tb_byte_stripping.sv
// Self-checking bench for byte_stripping: directed scenarios plus random traffic
// against a period-based reference model. Honours STRIPE_PARITY_EN.
module tb_byte_stripping;

  logic clk_2f = 1'b0;
  logic reset_L;

  byte_stripping_if #(.DATA_W(8)) bus ();

  byte_stripping #(
    .DATA_W    (8),
    .IDLE_BYTE (8'h00)
  ) dut (
    .clk_2f  (clk_2f),
    .reset_L (reset_L),
    .bus     (bus)
  );

  always #5 clk_2f = ~clk_2f;

  int checks   = 0;
  int failures = 0;

  // Reference model: bytes accepted within a (ph0, ph1) period, launched together.
  logic       ph_m;
  logic [7:0] pend[$];
  logic       e_v0, e_v1;
  logic [7:0] e_d0, e_d1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    if (!reset_L) begin
      ph_m = 1'b0;
      pend.delete();
      e_v0 = 1'b0; e_v1 = 1'b0; e_d0 = 8'h00; e_d1 = 8'h00;
    end else begin
      if (bus.valid_in) pend.push_back(bus.data_in);
      if (ph_m) begin
        e_v0 = (pend.size() >= 1);
        e_v1 = (pend.size() >= 2);
        e_d0 = e_v0 ? pend[0] : 8'h00;
        e_d1 = e_v1 ? pend[1] : 8'h00;
        pend.delete();
      end
      ph_m = ~ph_m;
    end
  endtask

  task automatic compare_all();
    check("valid0", bus.valid_stripe_0, e_v0);
    check("valid1", bus.valid_stripe_1, e_v1);
    check("data0",  bus.data_stripe_0,  e_d0);
    check("data1",  bus.data_stripe_1,  e_d1);
    check("v1_implies_v0", bus.valid_stripe_1 & ~bus.valid_stripe_0, 1'b0);
`ifdef STRIPE_PARITY_EN
    check("parity0", bus.parity_stripe_0, e_v0 & (^e_d0));
    check("parity1", bus.parity_stripe_1, e_v1 & (^e_d1));
`endif
  endtask

  task automatic cycle(input logic rst_n, input logic v, input logic [7:0] d);
    reset_L      = rst_n;
    bus.valid_in = v;
    bus.data_in  = d;
    @(posedge clk_2f);
    model_step();
    @(negedge clk_2f);
    compare_all();
  endtask

  task automatic align_ph0();
    if (ph_m) cycle(1'b1, 1'b0, 8'h00);
  endtask

  initial begin
    reset_L      = 1'b0;
    bus.valid_in = 1'b0;
    bus.data_in  = 8'h00;
    ph_m         = 1'b0;
    e_v0 = 1'b0; e_v1 = 1'b0; e_d0 = 8'h00; e_d1 = 8'h00;

    // Initial reset, then a stream interrupted by a 4-cycle reset.
    repeat (3) cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b1, 1'b1, 8'h11);
    cycle(1'b1, 1'b1, 8'h22);
    cycle(1'b1, 1'b1, 8'h33);
    repeat (4) cycle(1'b0, 1'b1, 8'hEE);
    check("rst_valid0", bus.valid_stripe_0, 1'b0);
    check("rst_valid1", bus.valid_stripe_1, 1'b0);
    check("rst_data0",  bus.data_stripe_0,  8'h00);
    check("rst_data1",  bus.data_stripe_1,  8'h00);
    // First cycle after release must be ph=0: byte pairs C1 with C2.
    cycle(1'b1, 1'b1, 8'hC1);
    cycle(1'b1, 1'b1, 8'hC2);
    check("post_rst_d0", bus.data_stripe_0, 8'hC1);
    check("post_rst_d1", bus.data_stripe_1, 8'hC2);

    // Continuous stream 01..06 from ph=0.
    align_ph0();
    for (int i = 0; i < 3; i++) begin
      logic [7:0] a, b;
      a = 8'(2 * i + 1);
      b = 8'(2 * i + 2);
      cycle(1'b1, 1'b1, a);
      if (i > 0) check("s2_hold_d0", bus.data_stripe_0, a - 8'd2);
      cycle(1'b1, 1'b1, b);
      check("s2_d0", bus.data_stripe_0, a);
      check("s2_d1", bus.data_stripe_1, b);
      check("s2_v1", bus.valid_stripe_1, 1'b1);
    end

    // Single byte AA at ph=0.
    cycle(1'b1, 1'b1, 8'hAA);
    cycle(1'b1, 1'b0, 8'h00);
    check("s3_d0", bus.data_stripe_0,  8'hAA);
    check("s3_v0", bus.valid_stripe_0, 1'b1);
    check("s3_d1", bus.data_stripe_1,  8'h00);
    check("s3_v1", bus.valid_stripe_1, 1'b0);

    // Single byte 55 at ph=1 only, visible one edge later.
    cycle(1'b1, 1'b0, 8'h00);
    cycle(1'b1, 1'b1, 8'h55);
    check("s4_d0", bus.data_stripe_0,  8'h55);
    check("s4_v0", bus.valid_stripe_0, 1'b1);
    check("s4_v1", bus.valid_stripe_1, 1'b0);

    // Byte 10 at ph=0 then reset at ph=1: 10 is dropped.
    align_ph0();
    cycle(1'b1, 1'b1, 8'h10);
    cycle(1'b0, 1'b0, 8'h00);
    check("s5_rst_v0", bus.valid_stripe_0, 1'b0);
    repeat (2) cycle(1'b1, 1'b0, 8'h00);
    check("s5_v0", bus.valid_stripe_0, 1'b0);
    check("s5_d0", bus.data_stripe_0,  8'h00);

    // Pair (07,03): parity 1 / 0 when enabled.
    align_ph0();
    cycle(1'b1, 1'b1, 8'h07);
    cycle(1'b1, 1'b1, 8'h03);
    check("s6_d0", bus.data_stripe_0, 8'h07);
    check("s6_d1", bus.data_stripe_1, 8'h03);
`ifdef STRIPE_PARITY_EN
    check("s6_par0", bus.parity_stripe_0, 1'b1);
    check("s6_par1", bus.parity_stripe_1, 1'b0);
`endif

    // Random traffic with occasional resets.
    for (int n = 0; n < 800; n++) begin
      cycle(($urandom_range(0, 49) != 0), ($urandom_range(0, 2) != 0), 8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
